pid_pwm_out: RTL
================

// Module: pid_pwm_out
// PURPOSE
//  Output stage of the servo PID loop, downstream of the P/I/D term calculators. Combines pk, ik, dk
//  into u = pk + ik - dk (derivative acts on feedback), saturates, scales to a duty magnitude and
//  direction, and drives an H-bridge PWM. Duty and direction are double-buffered and change only at
//  PWM period boundaries. A reversal inserts one forced-off period.
// PARAMETERS
//  TERM_W      19    width of signed pk/ik/dk inputs (two's complement)
//  ACC_W       21    internal sum width (TERM_W+2, no overflow possible)
//  UMAX        65535 saturation bound, |u| clamped to UMAX (UMAX < 2^(ACC_W-1))
//  SHIFT       6     right shift from |u| to duty counts
//  DUTY_W      10    duty / counter width
//  PWM_PERIOD  1000  counts per PWM period (<= 2^DUTY_W); duty range 0..PWM_PERIOD
// PORTS
//  clk        in   1       clock
//  rst        in   1       synchronous reset, active-high
//  in_valid   in   1       one-cycle strobe: pk/ik/dk valid this cycle
//  pk         in   TERM_W  proportional term, signed
//  ik         in   TERM_W  integral term, signed
//  dk         in   TERM_W  derivative term, signed
//  pwm_a      out  1       bridge leg A (forward, dir=0)
//  pwm_b      out  1       bridge leg B (reverse, dir=1)
//  sat        out  1       last accepted sample saturated (sticky until next sample)
//  upd_done   out  1       one-cycle pulse when a new duty becomes active at a period boundary
//  duty_act   out  DUTY_W  currently active duty
// BEHAVIOUR
//  Reset: pwm_a=pwm_b=0, sat=0, upd_done=0, duty_act=0, dir_act=0, cnt=0, shadow=0, pending=0, state=RUN.
//  Stage 1 (edge after in_valid): sum <= sext(pk)+sext(ik)-sext(dk), ACC_W bits.
//  Stage 2 (next edge): |sum| > UMAX -> mag=UMAX, sat<=1 else mag=|sum|, sat<=0; dir=sum<0;
//   duty=min(mag>>SHIFT, PWM_PERIOD); shadow_duty/shadow_dir <= duty/dir; pending<=1.
//   Latency in_valid -> shadow = 2 cycles. Back-to-back in_valid accepted every cycle; newest wins.
//  Counter: cnt 0..PWM_PERIOD-1, wrap at PWM_PERIOD-1 -> 0. Boundary = edge where cnt wraps.
//  Leg output (registered): active leg = (cnt < duty_act) in RUN; other leg 0; both 0 in GAP.
//   Never pwm_a & pwm_b simultaneously high.
//  FSM at each boundary, only if pending:
//   RUN, shadow_dir==dir_act or duty_act==0: load duty_act/dir_act from shadow, pending<=0, upd_done=1.
//   RUN, dir differs and duty_act!=0: duty_act<=0, -> GAP (pending stays 1).
//   GAP: at next boundary load shadow (latest value), pending<=0, upd_done=1, -> RUN.
//  Shadow write and boundary on same edge: boundary uses the old shadow; new value waits for the
//   next boundary (pending remains 1).
//  duty=0 -> leg constantly low; duty=PWM_PERIOD -> leg constantly high.
//  rst mid-period or mid-GAP: everything returns to reset values on that edge; in-flight pipeline dropped.
// STRUCTURE
//  Shared package pid_pkg: TERM_W, ACC_W, DUTY_W constants; state enum {RUN, GAP}; sat/abs helper function.
//  Sub-module pwm_hbridge_gen: counter, boundary strobe, leg compare; takes duty_act/dir_act/gap_en.
//  Top holds sum pipeline, shadow regs and RUN/GAP FSM.
// TESTING
//  1 pk=6400,ik=0,dk=0 strobe -> shadow 100 at +2 cycles; next boundary duty_act=100, upd_done pulse,
//    pwm_a high 100 of 1000 counts, pwm_b=0.
//  2 pk=200000,ik=0,dk=0 -> sat=1, duty_act=min(65535>>6=1023,1000)=1000, pwm_a constantly high;
//    pk=-200000 -> sat=1, dir=1, GAP path.
//  3 Forward duty 100 active, then pk=0,dk=6400 (u=-6400) -> one period both legs 0, then pwm_b duty 100.
//  4 in_valid timed so shadow write coincides with wrap edge -> old duty kept one more period,
//    new duty at following boundary.
//  5 Three back-to-back strobes (duty 10,20,30) within one period -> only 30 applied, single upd_done.
//  6 rst asserted mid-GAP and mid-period -> all outputs 0, cnt=0 next cycle; no upd_done until new sample.

Source files
------------

// File: rtl/pid_pkg.sv
// Shared constants, FSM state type and the sum-to-duty conversion for the servo PID output stage.
package pid_pkg;

    localparam int TERM_W     = 19;
    localparam int ACC_W      = TERM_W + 2;
    localparam int UMAX       = 65535;
    localparam int SHIFT      = 6;
    localparam int DUTY_W     = 10;
    localparam int PWM_PERIOD = 1000;

    typedef enum logic {
        RUN = 1'b0,
        GAP = 1'b1
    } pwm_state_e;

    typedef struct packed {
        logic [DUTY_W-1:0] duty;
        logic              dir;
        logic              sat;
    } duty_cmd_t;

    // |sum| clamped to UMAX, scaled down to counts and limited to a full period.
    function automatic duty_cmd_t sum_to_cmd(input logic signed [ACC_W-1:0] sum);
        logic [ACC_W-1:0] mag;
        logic [ACC_W-1:0] counts;
        duty_cmd_t        cmd;
        cmd.dir = sum[ACC_W-1];
        mag     = cmd.dir ? (~sum + ACC_W'(1)) : sum;
        if (mag > ACC_W'(UMAX)) begin
            mag     = ACC_W'(UMAX);
            cmd.sat = 1'b1;
        end else begin
            cmd.sat = 1'b0;
        end
        counts = mag >> SHIFT;
        if (counts > ACC_W'(PWM_PERIOD)) begin
            counts = ACC_W'(PWM_PERIOD);
        end
        cmd.duty = counts[DUTY_W-1:0];
        return cmd;
    endfunction

endpackage

// File: rtl/pwm_hbridge_gen.sv
// H-bridge PWM generator: free-running period counter, boundary strobe and registered leg compare.
module pwm_hbridge_gen
    import pid_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DUTY_W-1:0] duty_act,
    input  logic              dir_act,
    input  logic              gap_en,
    output logic              bnd,
    output logic              pwm_a,
    output logic              pwm_b
);

    logic [DUTY_W-1:0] cnt_reg;
    logic              on_time;

    assign bnd = (cnt_reg == DUTY_W'(PWM_PERIOD - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (bnd) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + DUTY_W'(1);
        end
    end

    // duty 0 never satisfies the compare, duty PWM_PERIOD always does.
    assign on_time = !gap_en && (cnt_reg < duty_act);

    // Leg 0 drives forward (dir 0), leg 1 reverse; only the leg matching dir_act can be high.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_leg
            logic leg_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    leg_reg <= 1'b0;
                end else begin
                    leg_reg <= on_time && (dir_act == 1'(gi));
                end
            end
        end
    endgenerate

    assign pwm_a = g_leg[0].leg_reg;
    assign pwm_b = g_leg[1].leg_reg;

endmodule

// File: rtl/pid_pwm_out.sv
// PID output stage: u = pk + ik - dk, saturate/scale to duty, double-buffer and apply at PWM
// period boundaries, inserting one forced-off period whenever the drive direction reverses.
module pid_pwm_out
    import pid_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [TERM_W-1:0] pk,
    input  logic [TERM_W-1:0] ik,
    input  logic [TERM_W-1:0] dk,
    output logic              pwm_a,
    output logic              pwm_b,
    output logic              sat,
    output logic              upd_done,
    output logic [DUTY_W-1:0] duty_act
);

    logic signed [ACC_W-1:0] sum_reg;
    logic                    sum_vld_reg;
    duty_cmd_t               cmd;

    logic [DUTY_W-1:0] shadow_duty_reg;
    logic              shadow_dir_reg;
    logic              pending_reg;
    logic              sat_reg;

    pwm_state_e        state_reg, state_next;
    logic [DUTY_W-1:0] duty_act_reg, duty_act_next;
    logic              dir_act_reg, dir_act_next;
    logic              upd_done_reg;
    logic              load;
    logic              bnd;

    // Stage 1: sign-extended sum; two guard bits make overflow impossible.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_vld_reg <= 1'b0;
            sum_reg     <= '0;
        end else begin
            sum_vld_reg <= in_valid;
            if (in_valid) begin
                sum_reg <= {{2{pk[TERM_W-1]}}, pk}
                         + {{2{ik[TERM_W-1]}}, ik}
                         - {{2{dk[TERM_W-1]}}, dk};
            end
        end
    end

    assign cmd = sum_to_cmd(sum_reg);

    // Stage 2: shadow write. A write on a boundary edge keeps pending set, so the new value
    // waits for the following boundary while the boundary itself saw the old shadow.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_duty_reg <= '0;
            shadow_dir_reg  <= 1'b0;
            sat_reg         <= 1'b0;
            pending_reg     <= 1'b0;
        end else begin
            if (sum_vld_reg) begin
                shadow_duty_reg <= cmd.duty;
                shadow_dir_reg  <= cmd.dir;
                sat_reg         <= cmd.sat;
                pending_reg     <= 1'b1;
            end else if (load) begin
                pending_reg     <= 1'b0;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        duty_act_next = duty_act_reg;
        dir_act_next  = dir_act_reg;
        load          = 1'b0;
        if (bnd) begin
            case (state_reg)
                RUN: begin
                    if (pending_reg) begin
                        if ((shadow_dir_reg == dir_act_reg) || (duty_act_reg == '0)) begin
                            load = 1'b1;
                        end else begin
                            duty_act_next = '0;
                            state_next    = GAP;
                        end
                    end
                end
                GAP: begin
                    load       = 1'b1;
                    state_next = RUN;
                end
                default: state_next = RUN;
            endcase
        end
        if (load) begin
            duty_act_next = shadow_duty_reg;
            dir_act_next  = shadow_dir_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= RUN;
            duty_act_reg <= '0;
            dir_act_reg  <= 1'b0;
            upd_done_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            duty_act_reg <= duty_act_next;
            dir_act_reg  <= dir_act_next;
            upd_done_reg <= load;
        end
    end

    pwm_hbridge_gen u_pwm (
        .clk      (clk),
        .rst      (rst),
        .duty_act (duty_act_reg),
        .dir_act  (dir_act_reg),
        .gap_en   (state_reg == GAP),
        .bnd      (bnd),
        .pwm_a    (pwm_a),
        .pwm_b    (pwm_b)
    );

    assign sat      = sat_reg;
    assign upd_done = upd_done_reg;
    assign duty_act = duty_act_reg;

endmodule
